// File: rtl/bcd_sched_pkg.sv
// rtl/bcd_sched_pkg.sv - shared constants, state encoding and digit correction for bcd_conv_sched
package bcd_sched_pkg;

   localparam int BIN_W  = 8;
   localparam int STEPS  = BIN_W;
   localparam int CNT_W  = $clog2(STEPS);
   localparam int BCD2_W = 2;
   localparam int BCD1_W = 4;
   localparam int BCD0_W = 4;
   localparam int ACC_W  = BCD2_W + BCD1_W + BCD0_W;

   localparam logic [3:0] CORR_THRESH = 4'd5;
   localparam logic [3:0] CORR_ADD    = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [3:0] dd_corr(input logic [3:0] d);
      return (d >= CORR_THRESH) ? d + CORR_ADD : d;
   endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// rtl/bcd_dd_step.sv - one double-dabble step: add-3 correction per digit, then shift in the next binary bit
module bcd_dd_step
   import bcd_sched_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic             bin_msb,
   output logic [ACC_W-1:0] acc_next
);

   logic [3:0] c2, c1, c0;

   // hundreds digit is widened to 4 bits for the shared correction and truncated on the shift
   assign c2 = dd_corr({2'b00, acc[BCD0_W+BCD1_W +: BCD2_W]});
   assign c1 = dd_corr(acc[BCD0_W +: BCD1_W]);
   assign c0 = dd_corr(acc[0 +: BCD0_W]);

   assign acc_next = ACC_W'({c2, c1, c0, bin_msb});

endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - two-requester scheduler around one iterative binary-to-BCD engine
// BCD_SCHED_RR_EN: round-robin arbitration when defined, fixed priority to requester 0 otherwise
module bcd_conv_sched
   import bcd_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [BIN_W-1:0]  bin0,
   input  logic              req1,
   input  logic [BIN_W-1:0]  bin1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              busy,
   output logic              out_valid,
   output logic              out_id,
   output logic [BCD2_W-1:0] bcd2,
   output logic [BCD1_W-1:0] bcd1,
   output logic [BCD0_W-1:0] bcd0
);

   state_t            state, state_next;
   logic [BIN_W-1:0]  sh;
   logic [ACC_W-1:0]  acc, acc_next;
   logic [CNT_W-1:0]  cnt;
   logic              cur_id;
   logic              take0, take1;
   logic              last_step;

`ifdef BCD_SCHED_RR_EN
   logic              last;
`endif

   bcd_dd_step u_step (
      .acc      (acc),
      .bin_msb  (sh[BIN_W-1]),
      .acc_next (acc_next)
   );

   assign last_step = (cnt == CNT_W'(STEPS-1));
   assign busy      = (state != IDLE);

   always_comb begin
      state_next = state;
      take0      = 1'b0;
      take1      = 1'b0;
      case (state)
         IDLE: begin
`ifdef BCD_SCHED_RR_EN
            // on contention the requester not granted last time wins
            if (req0 && req1) begin
               take0 = last;
               take1 = ~last;
            end else begin
               take0 = req0;
               take1 = req1;
            end
`else
            take0 = req0;
            take1 = req1 & ~req0;
`endif
            if (req0 || req1)
               state_next = SHIFT;
         end
         SHIFT: begin
            if (last_step)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh        <= '0;
         acc       <= '0;
         cnt       <= '0;
         cur_id    <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         out_valid <= 1'b0;
         out_id    <= 1'b0;
         bcd2      <= '0;
         bcd1      <= '0;
         bcd0      <= '0;
      end else begin
         gnt0      <= take0;
         gnt1      <= take1;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (take0 || take1) begin
                  sh     <= take0 ? bin0 : bin1;
                  acc    <= '0;
                  cnt    <= '0;
                  cur_id <= take1;
               end
            end
            SHIFT: begin
               acc <= acc_next;
               sh  <= {sh[BIN_W-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (last_step) begin
                  bcd2      <= acc_next[BCD0_W+BCD1_W +: BCD2_W];
                  bcd1      <= acc_next[BCD0_W +: BCD1_W];
                  bcd0      <= acc_next[0 +: BCD0_W];
                  out_id    <= cur_id;
                  out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_SCHED_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (take0)
         last <= 1'b0;
      else if (take1)
         last <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - randomized self-checking bench for bcd_conv_sched against a cycle-level reference model
// BCD_SCHED_RR_EN selects the round-robin expectations, matching the design build
module tb_bcd_conv_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] bin0, bin1;
   logic       gnt0, gnt1, busy, out_valid, out_id;
   logic [1:0] bcd2;
   logic [3:0] bcd1, bcd0;

   bcd_conv_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .bin0      (bin0),
      .req1      (req1),
      .bin1      (bin1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .busy      (busy),
      .out_valid (out_valid),
      .out_id    (out_id),
      .bcd2      (bcd2),
      .bcd1      (bcd1),
      .bcd0      (bcd0)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int          cyc = 0;
   int          m_left = 0;
   int          m_due = 0;
   logic        m_pend = 1'b0;
   logic        m_last = 1'b1;
   logic        m_g, m_g0, m_g1, exp_ov;
   logic [7:0]  m_val = '0;
   logic        m_id = 1'b0;
   logic [10:0] hold = '0;
   int          dut_g_cyc = 0;
   int          dut_g0_cnt = 0, dut_g1_cnt = 0, dut_ov_cnt = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      m_g = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; exp_ov = 1'b0;
      if (rst) begin
         m_left = 0; m_pend = 1'b0; m_last = 1'b1; hold = '0;
      end else begin
         if (m_left == 0) begin
            if (req0 || req1) begin
`ifdef BCD_SCHED_RR_EN
               m_g0 = (req0 && req1) ? m_last : req0;
`else
               m_g0 = req0;
`endif
               m_g1   = ~m_g0;
               m_last = m_g1;
               m_val  = m_g0 ? bin0 : bin1;
               m_id   = m_g1;
               m_due  = cyc + 8;
               m_pend = 1'b1;
               m_left = 9;
               m_g    = 1'b1;
            end
         end else begin
            m_left--;
         end
         if (m_pend && cyc == m_due) begin
            exp_ov = 1'b1;
            m_pend = 1'b0;
         end
      end
      if (exp_ov)
         hold = {m_id, 2'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)};
      check_eq("gnt0", gnt0, m_g0);
      check_eq("gnt1", gnt1, m_g1);
      check_eq("busy", busy, m_left != 0);
      check_eq("out_valid", out_valid, exp_ov);
      check_eq("result_hold", {out_id, bcd2, bcd1, bcd0}, hold);
      if (gnt0 || gnt1) dut_g_cyc = cyc;
      if (gnt0) dut_g0_cnt++;
      if (gnt1) dut_g1_cnt++;
      if (out_valid) dut_ov_cnt++;
   endtask

   task automatic wait_grant();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!m_g && n < 30);
      check_eq("grant_seen", m_g, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_eq("rst_outputs", {gnt0, gnt1, busy, out_valid, out_id, bcd2, bcd1, bcd0}, 0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g_first, g1_base, ov_base, g0_base, k, guard, exp_id, prev_g;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
      tick();
      tick();
      check_eq("reset_state", {gnt0, gnt1, busy, out_valid, out_id, bcd2, bcd1, bcd0}, 0);
      rst = 1'b0;
      tick();

      // single request of 255
      req0 = 1'b1; bin0 = 8'd255;
      wait_grant();
      req0 = 1'b0;
      check_eq("t1_gnt0", gnt0, 1);
      tick();
      check_eq("t1_gnt0_pulse", gnt0, 0);
      repeat (7) tick();
      check_eq("t1_ov", out_valid, 1);
      check_eq("t1_result", {out_id, bcd2, bcd1, bcd0}, {1'b0, 2'd2, 4'd5, 4'd5});
      repeat (3) tick();

      // simultaneous requests right after reset
      do_reset();
      req0 = 1'b1; bin0 = 8'd0; req1 = 1'b1; bin1 = 8'd99;
      wait_grant();
      check_eq("t2_first_gnt0", gnt0, 1);
      req0 = 1'b0;
      g_first = dut_g_cyc;
      repeat (8) tick();
      check_eq("t2_first_ov", out_valid, 1);
      check_eq("t2_first_result", {out_id, bcd2, bcd1, bcd0}, 0);
      wait_grant();
      check_eq("t2_second_gnt1", gnt1, 1);
      check_eq("t2_spacing", dut_g_cyc - g_first, 10);
      req1 = 1'b0;
      repeat (8) tick();
      check_eq("t2_second_ov", out_valid, 1);
      check_eq("t2_second_result", {out_id, bcd2, bcd1, bcd0}, {1'b1, 2'd0, 4'd9, 4'd9});
      repeat (3) tick();

      // both requesters held for six conversions
      do_reset();
      bin0 = 8'($urandom); bin1 = 8'($urandom);
      req0 = 1'b1; req1 = 1'b1;
      g1_base = dut_g1_cnt;
      k = 0; guard = 0;
      while (k < 6 && guard < 100) begin
         tick();
         guard++;
         if (exp_ov) begin
`ifdef BCD_SCHED_RR_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            check_eq("t3_out_id", out_id, exp_id);
            k++;
         end
      end
      check_eq("t3_conversions", k, 6);
      req0 = 1'b0; req1 = 1'b0;
`ifdef BCD_SCHED_RR_EN
      check_eq("t3_gnt1_count", dut_g1_cnt - g1_base, 3);
`else
      check_eq("t3_gnt1_count", dut_g1_cnt - g1_base, 0);
`endif
      repeat (12) tick();

      // reset in the middle of a conversion
      bin0 = 8'($urandom); req0 = 1'b1;
      wait_grant();
      req0 = 1'b0;
      repeat (4) tick();
      ov_base = dut_ov_cnt;
      do_reset();
      repeat (12) tick();
      check_eq("t4_no_ov_after_rst", dut_ov_cnt - ov_base, 0);
      req1 = 1'b1; bin1 = 8'd128;
      wait_grant();
      req1 = 1'b0;
      repeat (8) tick();
      check_eq("t4_ov", out_valid, 1);
      check_eq("t4_result", {out_id, bcd2, bcd1, bcd0}, {1'b1, 2'd1, 4'd2, 4'd8});
      repeat (3) tick();

      // full sweep, back-to-back, random requester per value
      prev_g = 0;
      for (int v = 0; v < 256; v++) begin
         if ($urandom_range(1, 0) == 1) begin
            req1 = 1'b1; bin1 = 8'(v);
         end else begin
            req0 = 1'b1; bin0 = 8'(v);
         end
         wait_grant();
         req0 = 1'b0; req1 = 1'b0;
         if (v > 0)
            check_eq("t5_spacing", dut_g_cyc - prev_g, 10);
         prev_g = dut_g_cyc;
      end
      repeat (12) tick();

      // request raised and dropped while busy is ignored
      bin1 = 8'($urandom); req1 = 1'b1;
      wait_grant();
      req1 = 1'b0;
      g0_base = dut_g0_cnt;
      ov_base = dut_ov_cnt;
      repeat (3) tick();
      bin0 = 8'($urandom); req0 = 1'b1;
      repeat (3) tick();
      req0 = 1'b0;
      repeat (15) tick();
      check_eq("t6_no_gnt0", dut_g0_cnt - g0_base, 0);
      check_eq("t6_one_ov", dut_ov_cnt - ov_base, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
